axis_skid_buffer: RTL and testbench

//   Two-entry valid/ready pipeline register (skid buffer) for a data+last stream.

---
 rtl/axis_skid_buffer.sv | 144 ++++++++++++++
 tb/tb_axis_skid_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer
//
// Two-entry valid/ready pipeline register (skid buffer) for a data+last
// stream. Every output is driven directly from a flop, so there is no
// combinational path from s_valid to m_valid or from m_ready to s_ready.
// The buffer sustains one beat per cycle while the downstream is ready.
// When the downstream stalls, the second register (the skid entry) absorbs
// the one beat that was already in flight.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both 1. Once valid is raised it stays high, with its payload stable, until
// that transfer happens. s_ready is registered, so an upstream beat offered
// while s_ready=1 is always taken at that edge.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        synchronous active-low reset
//   s_valid    in   1        upstream beat valid
//   s_ready    out  1        buffer can accept a beat (registered)
//   s_data     in   DATA_W   upstream payload
//   s_last     in   1        upstream end-of-packet flag
//   m_valid    out  1        downstream beat valid (registered)
//   m_ready    in   1        downstream accepts beat
//   m_data     out  DATA_W   downstream payload (registered)
//   m_last     out  1        downstream end-of-packet flag (registered)
//   state_dbg  out  2        current occupancy state (0=EMPTY, 1=ONE, 2=FULL)

`timescale 1ns/1ps

module axis_skid_buffer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic                s_ready_q;
   logic [DATA_W-1:0]   m_data_q;
   logic                m_last_q;
   logic [DATA_W-1:0]   sk_data_q;
   logic                sk_last_q;

   logic                acc;
   logic                snd;
   logic                load_out;
   logic                load_out_from_skid;
   logic                load_skid;

   // m_valid is a decode of the state flops only, so it stays free of
   // combinational input paths. sk_valid is equivalent to state == ST_FULL.
   assign m_valid   = (state != ST_EMPTY);
   assign s_ready   = s_ready_q;
   assign m_data    = m_data_q;
   assign m_last    = m_last_q;
   assign state_dbg = state;

   assign acc = s_valid & s_ready_q;
   assign snd = m_valid & m_ready;

   always_comb begin
      state_nxt          = state;
      load_out           = 1'b0;
      load_out_from_skid = 1'b0;
      load_skid          = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (acc) begin
               state_nxt = ST_ONE;
               load_out  = 1'b1;
            end
         end
         ST_ONE: begin
            if (acc && snd) begin
               load_out = 1'b1;
            end else if (acc && !snd) begin
               // Output is stalled: park the incoming beat in the skid entry.
               state_nxt = ST_FULL;
               load_skid = 1'b1;
            end else if (!acc && snd) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // s_ready is low here, so no upstream beat can arrive.
            if (snd) begin
               state_nxt          = ST_ONE;
               load_out           = 1'b1;
               load_out_from_skid = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         s_ready_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         sk_data_q <= '0;
         sk_last_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         // s_ready is computed from the next state so that it is high exactly
         // when the skid entry will be free in the coming cycle.
         s_ready_q <= (state_nxt != ST_FULL);
         if (load_out) begin
            if (load_out_from_skid) begin
               m_data_q <= sk_data_q;
               m_last_q <= sk_last_q;
            end else begin
               m_data_q <= s_data;
               m_last_q <= s_last;
            end
         end
         if (load_skid) begin
            sk_data_q <= s_data;
            sk_last_q <= s_last;
         end
      end
   end

endmodule

// File: tb/tb_axis_skid_buffer.sv
`timescale 1ns/1ps

module tb_axis_skid_buffer;

   localparam int DATA_W = 32;

   logic              clk;
   logic              rst_n;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              s_last;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;
   logic [1:0]        state_dbg;

   int n_checks;
   int n_fail;

   logic [DATA_W:0] exp_q[$];

   typedef struct {
      logic              s_valid;
      logic [DATA_W-1:0] s_data;
      logic              s_last;
      logic              m_ready;
      logic              exp_s_ready;
      logic              exp_m_valid;
      logic [DATA_W-1:0] exp_m_data;
      logic              exp_m_last;
   } vec_t;

   vec_t vecs_a[$];
   vec_t vecs_b[$];

   axis_skid_buffer #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input int idx, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got 0x%0h required 0x%0h", name, idx, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic sv, input logic [DATA_W-1:0] sd, input logic sl,
                               input logic mr, input logic e_sr, input logic e_mv,
                               input logic [DATA_W-1:0] e_md, input logic e_ml);
      vec_t v;
      v.s_valid     = sv;
      v.s_data      = sd;
      v.s_last      = sl;
      v.m_ready     = mr;
      v.exp_s_ready = e_sr;
      v.exp_m_valid = e_mv;
      v.exp_m_data  = e_md;
      v.exp_m_last  = e_ml;
      return v;
   endfunction

   // Drive one vector, clock once, and compare the registered outputs.
   task automatic apply_vec(input string tag, input int idx, input vec_t v);
      s_valid = v.s_valid;
      s_data  = v.s_data;
      s_last  = v.s_last;
      m_ready = v.m_ready;
      @(posedge clk);
      #1;
      check({tag, "_s_ready"}, idx, 64'(s_ready), 64'(v.exp_s_ready));
      check({tag, "_m_valid"}, idx, 64'(m_valid), 64'(v.exp_m_valid));
      check({tag, "_m_data"},  idx, 64'(m_data),  64'(v.exp_m_data));
      check({tag, "_m_last"},  idx, 64'(m_last),  64'(v.exp_m_last));
   endtask

   task automatic step_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------- random-stall stream ----------------
   task automatic producer();
      logic [DATA_W-1:0] bdata [9];
      logic              blast [9];
      logic              accepted;
      int k;
      k = 0;
      for (int i = 0; i < 3; i++) begin bdata[k] = 32'h1000 + i; blast[k] = (i == 2); k++; end
      bdata[k] = 32'h2000; blast[k] = 1'b1; k++;
      for (int i = 0; i < 5; i++) begin bdata[k] = 32'h3000 + i; blast[k] = (i == 4); k++; end
      for (int b = 0; b < 9; b++) begin
         if ($urandom_range(0, 4) == 0) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
         end
         s_valid  = 1'b1;
         s_data   = bdata[b];
         s_last   = blast[b];
         accepted = 1'b0;
         for (int c = 0; c < 200 && !accepted; c++) begin
            accepted = s_ready;
            if (accepted) exp_q.push_back({blast[b], bdata[b]});
            @(posedge clk);
            #1;
         end
         if (!accepted) check("t5_accept_timeout", b, 64'(0), 64'(1));
      end
      s_valid = 1'b0;
   endtask

   task automatic consumer();
      int              got;
      int              stall_left;
      logic            pre_valid;
      logic [DATA_W:0] pre_beat;
      logic            snd;
      logic [DATA_W:0] exp;
      got        = 0;
      stall_left = 0;
      for (int cyc = 0; cyc < 2000 && got < 9; cyc++) begin
         if (stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
         end else if ($urandom_range(0, 9) == 0) begin
            m_ready    = 1'b0;
            stall_left = $urandom_range(1, 5) - 1;
         end else begin
            m_ready = 1'b1;
         end
         pre_valid = m_valid;
         pre_beat  = {m_last, m_data};
         snd       = m_valid && m_ready;
         @(posedge clk);
         #1;
         if (snd) begin
            if (exp_q.size() == 0) begin
               check("t5_extra_beat", got, 64'(pre_beat), 64'(0));
            end else begin
               exp = exp_q.pop_front();
               check("t5_beat", got, 64'(pre_beat), 64'(exp));
            end
            got++;
         end else if (pre_valid) begin
            check("t5_hold_valid", got, 64'(m_valid), 64'(1));
            check("t5_hold_beat", got, 64'({m_last, m_data}), 64'(pre_beat));
         end
      end
      check("t5_beats_received", 0, 64'(got), 64'(9));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      s_valid  = 1'b0;
      s_data   = '0;
      s_last   = 1'b0;
      m_ready  = 1'b0;

      // Streaming, backpressure and simultaneous accept/send. Starts from EMPTY.
      //                 sv  s_data       sl  mr   sr  mv  m_data       ml
      vecs_a.push_back(mk(1, 32'h1000,     0,  1,   1,  1,  32'h1000,     0));
      vecs_a.push_back(mk(1, 32'h1001,     0,  1,   1,  1,  32'h1001,     0));
      vecs_a.push_back(mk(1, 32'h1002,     1,  1,   1,  1,  32'h1002,     1));
      vecs_a.push_back(mk(0, 32'h0,        0,  1,   1,  0,  32'h1002,     1));
      vecs_a.push_back(mk(1, 32'h2000,     0,  0,   1,  1,  32'h2000,     0));
      vecs_a.push_back(mk(1, 32'h2001,     1,  0,   0,  1,  32'h2000,     0));
      vecs_a.push_back(mk(1, 32'h2002,     0,  0,   0,  1,  32'h2000,     0));
      vecs_a.push_back(mk(0, 32'h0,        0,  1,   1,  1,  32'h2001,     1));
      vecs_a.push_back(mk(0, 32'h0,        0,  1,   1,  0,  32'h2001,     1));
      vecs_a.push_back(mk(1, 32'h3000,     0,  1,   1,  1,  32'h3000,     0));
      vecs_a.push_back(mk(1, 32'h3001,     0,  1,   1,  1,  32'h3001,     0));
      vecs_a.push_back(mk(1, 32'h3002,     1,  1,   1,  1,  32'h3002,     1));
      vecs_a.push_back(mk(0, 32'h0,        0,  0,   1,  1,  32'h3002,     1));
      vecs_a.push_back(mk(0, 32'h0,        0,  1,   1,  0,  32'h3002,     1));

      // Fill to FULL before the mid-operation reset.
      vecs_b.push_back(mk(1, 32'h4000,     0,  0,   1,  1,  32'h4000,     0));
      vecs_b.push_back(mk(1, 32'h4001,     1,  0,   0,  1,  32'h4000,     0));

      // Reset for 5 cycles.
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("rst_m_valid", i, 64'(m_valid), 64'(0));
         check("rst_s_ready", i, 64'(s_ready), 64'(0));
         check("rst_m_data",  i, 64'(m_data),  64'(0));
         check("rst_m_last",  i, 64'(m_last),  64'(0));
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("idle_s_ready", i, 64'(s_ready), 64'(1));
         check("idle_m_valid", i, 64'(m_valid), 64'(0));
      end

      for (int i = 0; i < vecs_a.size(); i++) apply_vec("vec_a", i, vecs_a[i]);

      // Random downstream stalls over three packets.
      fork
         producer();
         consumer();
      join
      s_valid = 1'b0;
      m_ready = 1'b1;
      step_idle(2);
      check("t5_queue_empty", 0, 64'(exp_q.size()), 64'(0));
      check("t5_drained_m_valid", 0, 64'(m_valid), 64'(0));
      check("t5_drained_s_ready", 0, 64'(s_ready), 64'(1));

      for (int i = 0; i < vecs_b.size(); i++) apply_vec("vec_b", i, vecs_b[i]);

      // Reset while FULL: both entries are discarded.
      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_data  = 32'h5000;
      s_last  = 1'b1;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      check("full_rst_m_valid", 0, 64'(m_valid), 64'(0));
      check("full_rst_s_ready", 0, 64'(s_ready), 64'(0));
      check("full_rst_m_data",  0, 64'(m_data),  64'(0));
      rst_n   = 1'b1;
      s_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("post_rst_m_valid", i, 64'(m_valid), 64'(0));
         check("post_rst_s_ready", i, 64'(s_ready), 64'(1));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
